// File: rtl/flash_array_ctrl.sv
// Wishbone responder sequencing read/program operations on the 8x8 flash array.
// Decodes rows into WL/SSL/GSL enables and times the sense/program phases.
`timescale 1ns/1ps
module flash_array_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          T_PRE     = 4,
  parameter int          T_SENSE   = 8,
  parameter int          T_PGM     = 64,
  parameter int          T_DIS     = 2
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_ack_o,
  input  logic [7:0]  array_out,
  output logic        sen1,
  output logic        sen2,
  output logic [3:0]  out_en,
  output logic [7:0]  wl_en,
  output logic [1:0]  ssl_en,
  output logic [1:0]  gsl_en,
  output logic        pgm_en,
  output logic [7:0]  bl_data,
  output logic        busy,
  output logic        irq
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SENSE1,
    S_SENSE2,
    S_CAPTURE,
    S_PGM,
    S_DISCH
  } state_t;

  localparam logic [15:0] L_PRE   = 16'(T_PRE - 1);
  localparam logic [15:0] L_SENSE = 16'(T_SENSE - 1);
  localparam logic [15:0] L_PGM   = 16'(T_PGM - 1);
  localparam logic [15:0] L_DIS   = 16'(T_DIS - 1);

  state_t      state;
  state_t      nxt;
  logic [15:0] cnt;
  logic [15:0] cnt_nxt;
  logic        done_evt;
  logic        cap_evt;

  logic        op;
  logic [2:0]  row;
  logic        irq_en;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic        done;
  logic        overrun;
  logic        go;

  logic        hit;
  logic        wr;
  logic [1:0]  idx;
  logic [31:0] rd_mux;

  logic        act_d;
  logic        sen1_d;
  logic        sen2_d;
  logic [3:0]  out_en_d;
  logic [7:0]  wl_en_d;
  logic [1:0]  sg_d;
  logic        pgm_en_d;
  logic [7:0]  bl_data_d;

  logic        unused_bits;
  assign unused_bits = ^{wbs_sel_i[3:1], wbs_adr_i[1:0],
                         wbs_dat_i[31:8]};

  assign hit = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o
             & (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign wr  = hit & wbs_we_i & wbs_sel_i[0];
  assign idx = wbs_adr_i[3:2];

  assign busy = (state != S_IDLE);
  assign irq  = done & irq_en;

  always_comb begin
    rd_mux = 32'h0;
    unique case (1'b1)
      idx == 2'd0: rd_mux = {26'h0, irq_en, row, op, 1'b0};
      idx == 2'd1: rd_mux = {24'h0, wdata};
      idx == 2'd2: rd_mux = {24'h0, rdata};
      idx == 2'd3: rd_mux = {29'h0, overrun, done, busy};
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state <= S_IDLE;
      cnt   <= 16'h0;
    end else begin
      state <= nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    nxt      = state;
    cnt_nxt  = (cnt == 16'h0) ? 16'h0 : cnt - 16'h1;
    done_evt = 1'b0;
    cap_evt  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (go) begin
          nxt     = S_SETUP;
          cnt_nxt = L_PRE;
        end
      end
      S_SETUP: begin
        if (cnt == 16'h0) begin
          nxt     = op ? S_PGM : S_SENSE1;
          cnt_nxt = op ? L_PGM : L_SENSE;
        end
      end
      S_SENSE1: begin
        if (cnt == 16'h0) begin
          nxt     = S_SENSE2;
          cnt_nxt = L_SENSE;
        end
      end
      S_SENSE2: begin
        if (cnt == 16'h0) begin
          nxt     = S_CAPTURE;
          cnt_nxt = 16'h0;
        end
      end
      S_CAPTURE: begin
        cap_evt = 1'b1;
        nxt     = S_DISCH;
        cnt_nxt = L_DIS;
      end
      S_PGM: begin
        if (cnt == 16'h0) begin
          nxt     = S_DISCH;
          cnt_nxt = L_DIS;
        end
      end
      S_DISCH: begin
        if (cnt == 16'h0) begin
          nxt      = S_IDLE;
          done_evt = 1'b1;
        end
      end
      default: nxt = S_IDLE;
    endcase
  end

  // Array controls are computed from the next state and registered.
  always_comb begin
    act_d = (nxt == S_SETUP) || (nxt == S_SENSE1)
         || (nxt == S_SENSE2) || (nxt == S_CAPTURE)
         || (nxt == S_PGM);
    sen1_d   = (nxt == S_SENSE1) || (nxt == S_SENSE2)
            || (nxt == S_CAPTURE);
    sen2_d   = (nxt == S_SENSE2) || (nxt == S_CAPTURE);
    out_en_d = (nxt == S_CAPTURE) ? 4'hF : 4'h0;
    wl_en_d  = act_d ? (8'd1 << row) : 8'h0;
    sg_d     = act_d ? (row[2] ? 2'b10 : 2'b01) : 2'b00;
    pgm_en_d = (nxt == S_PGM);
    bl_data_d = 8'h0;
    if (nxt == S_PGM)
      bl_data_d = (state == S_PGM) ? bl_data : wdata;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      sen1    <= 1'b0;
      sen2    <= 1'b0;
      out_en  <= 4'h0;
      wl_en   <= 8'h0;
      ssl_en  <= 2'b00;
      gsl_en  <= 2'b00;
      pgm_en  <= 1'b0;
      bl_data <= 8'h0;
    end else begin
      sen1    <= sen1_d;
      sen2    <= sen2_d;
      out_en  <= out_en_d;
      wl_en   <= wl_en_d;
      ssl_en  <= sg_d;
      gsl_en  <= sg_d;
      pgm_en  <= pgm_en_d;
      bl_data <= bl_data_d;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= 32'h0;
      op        <= 1'b0;
      row       <= 3'h0;
      irq_en    <= 1'b0;
      wdata     <= 8'h0;
      rdata     <= 8'h0;
      done      <= 1'b0;
      overrun   <= 1'b0;
      go        <= 1'b0;
    end else begin
      wbs_ack_o <= hit;
      wbs_dat_o <= (hit & ~wbs_we_i) ? rd_mux : 32'h0;
      go        <= 1'b0;
      if (cap_evt)
        rdata <= array_out;
      if (wr) begin
        unique case (1'b1)
          idx == 2'd0: begin
            if (wbs_dat_i[0]) begin
              if (busy) begin
                overrun <= 1'b1;
              end else begin
                op     <= wbs_dat_i[1];
                row    <= wbs_dat_i[4:2];
                irq_en <= wbs_dat_i[5];
                done   <= 1'b0;
                go     <= 1'b1;
              end
            end else begin
              irq_en <= wbs_dat_i[5];
              if (!busy) begin
                op  <= wbs_dat_i[1];
                row <= wbs_dat_i[4:2];
              end
            end
          end
          idx == 2'd1: wdata <= wbs_dat_i[7:0];
          idx == 2'd2: ;
          idx == 2'd3: begin
            if (wbs_dat_i[1]) done    <= 1'b0;
            if (wbs_dat_i[2]) overrun <= 1'b0;
          end
        endcase
      end
      // Completion overrides a same-cycle done clear.
      if (done_evt)
        done <= 1'b1;
    end
  end

endmodule
